// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Register scoreboard for a pipelined core. Tracks which
//               registers have a long-latency write (load, multi-cycle
//               mul/div) in flight. Produces fetch/decode stalls for RAW,
//               WAW and in-flight-capacity hazards, and decode/execute
//               flushes for taken branches.
// Ports       : clk          - clock, state changes on rising edge
//               rst          - asynchronous active-low reset
//               Valid_D      - decode holds a valid instruction
//               Rs1_D/Rs2_D  - decode source registers
//               Rd_D         - decode destination register
//               RegWrite_D   - decode instruction writes Rd_D
//               LongOp_D     - decode instruction is long-latency
//               Done_W       - long-latency result writes back this cycle
//               Rd_W         - destination of the completing result
//               PCSrc_E      - taken branch/jump resolved in execute
//               Stall_F/D    - hold fetch / decode
//               Flush_D/E    - bubble decode / execute
//               Pending      - per-register outstanding-write vector
//               OutCount     - number of long writes in flight
//               ErrSpurious  - sticky: completion with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Valid_D,
    input  logic [4:0]  Rs1_D,
    input  logic [4:0]  Rs2_D,
    input  logic [4:0]  Rd_D,
    input  logic        RegWrite_D,
    input  logic        LongOp_D,
    input  logic        Done_W,
    input  logic [4:0]  Rd_W,
    input  logic        PCSrc_E,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Flush_D,
    output logic        Flush_E,
    output logic [31:0] Pending,
    output logic [3:0]  OutCount,
    output logic        ErrSpurious
);

    localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUT);

    logic [31:0] r_pending;
    logic [3:0]  r_count;
    logic        r_err;

    logic [31:0] w_clr_hit;
    logic [31:0] w_eff_pending;
    logic [31:0] w_set_vec;
    logic [31:0] w_clr_vec;
    logic        w_raw;
    logic        w_waw;
    logic        w_cap;
    logic        w_stall;
    logic        w_issue;
    logic        w_done_valid;
    logic        w_done_spurious;

    // One-hot of the register completing this cycle; x0 never matches.
    assign w_clr_hit = (Done_W && (Rd_W != 5'd0)) ? (32'd1 << Rd_W) : 32'd0;

    // The register file is write-first, so a same-cycle completion already
    // satisfies a consumer in decode.
    assign w_eff_pending = r_pending & ~w_clr_hit;

    assign w_raw = Valid_D &&
                   (((Rs1_D != 5'd0) && w_eff_pending[Rs1_D]) ||
                    ((Rs2_D != 5'd0) && w_eff_pending[Rs2_D]));

    assign w_waw = Valid_D && RegWrite_D && (Rd_D != 5'd0) && w_eff_pending[Rd_D];

    // Any completion this cycle frees a slot in time for the new issue.
    assign w_cap = Valid_D && LongOp_D && (r_count == c_MAX_OUT) && !Done_W;

    // A redirect kills the decode instruction, so it must not be held.
    assign w_stall = (w_raw || w_waw || w_cap) && !PCSrc_E;

    assign w_issue = Valid_D && LongOp_D && RegWrite_D && (Rd_D != 5'd0) &&
                     !w_stall && !PCSrc_E;

    // Only a completion for a register actually outstanding retires an entry.
    assign w_done_valid    = Done_W && r_pending[Rd_W];
    assign w_done_spurious = Done_W && !r_pending[Rd_W];

    assign w_set_vec = w_issue ? (32'd1 << Rd_D) : 32'd0;
    assign w_clr_vec = w_done_valid ? (32'd1 << Rd_W) : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 32'd0;
            r_count   <= 4'd0;
            r_err     <= 1'b0;
        end else begin
            // Set applied after clear: a same-register issue is the younger
            // write and keeps the bit.
            r_pending <= ((r_pending & ~w_clr_vec) | w_set_vec) & 32'hFFFF_FFFE;

            // Saturating guards keep the counter in range even if a spurious
            // completion lets an issue through at full capacity.
            case ({w_issue, w_done_valid})
                2'b10: if (r_count != c_MAX_OUT) r_count <= r_count + 4'd1;
                2'b01: if (r_count != 4'd0)      r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase

            if (w_done_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    assign Stall_F     = w_stall;
    assign Stall_D     = w_stall;
    assign Flush_D     = PCSrc_E;
    assign Flush_E     = PCSrc_E || w_stall;
    assign Pending     = r_pending;
    assign OutCount    = r_count;
    assign ErrSpurious = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. A table of
//               directed vectors (inputs, expected combinational outputs,
//               expected state after the edge) followed by hand-written
//               sequences for asynchronous reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        Valid_D;
    logic [4:0]  Rs1_D;
    logic [4:0]  Rs2_D;
    logic [4:0]  Rd_D;
    logic        RegWrite_D;
    logic        LongOp_D;
    logic        Done_W;
    logic [4:0]  Rd_W;
    logic        PCSrc_E;
    logic        Stall_F;
    logic        Stall_D;
    logic        Flush_D;
    logic        Flush_E;
    logic [31:0] Pending;
    logic [3:0]  OutCount;
    logic        ErrSpurious;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(.MAX_OUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .Valid_D     (Valid_D),
        .Rs1_D       (Rs1_D),
        .Rs2_D       (Rs2_D),
        .Rd_D        (Rd_D),
        .RegWrite_D  (RegWrite_D),
        .LongOp_D    (LongOp_D),
        .Done_W      (Done_W),
        .Rd_W        (Rd_W),
        .PCSrc_E     (PCSrc_E),
        .Stall_F     (Stall_F),
        .Stall_D     (Stall_D),
        .Flush_D     (Flush_D),
        .Flush_E     (Flush_E),
        .Pending     (Pending),
        .OutCount    (OutCount),
        .ErrSpurious (ErrSpurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        lo;
        logic        dn;
        logic [4:0]  rdw;
        logic        pc;
        logic [2:0]  exp_sff;   // {Stall_D, Flush_D, Flush_E} before the edge
        logic [31:0] exp_pend;  // state after the edge
        logic [3:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] b(input int n);
        return 32'd1 << n;
    endfunction

    function automatic vec_t mk(input string nm, input logic v, input int rs1,
                                input int rs2, input int rd, input logic rw,
                                input logic lo, input logic dn, input int rdw,
                                input logic pc, input logic [2:0] sff,
                                input logic [31:0] pend, input int cnt,
                                input logic err);
        vec_t t;
        t.name = nm; t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
        t.rw = rw; t.lo = lo; t.dn = dn; t.rdw = 5'(rdw); t.pc = pc;
        t.exp_sff = sff; t.exp_pend = pend; t.exp_cnt = 4'(cnt); t.exp_err = err;
        return t;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                         input logic rw, input logic lo, input logic dn,
                         input int rdw, input logic pc);
        Valid_D = v; Rs1_D = 5'(rs1); Rs2_D = 5'(rs2); Rd_D = 5'(rd);
        RegWrite_D = rw; LongOp_D = lo; Done_W = dn; Rd_W = 5'(rdw); PCSrc_E = pc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_state(input string nm, input logic [31:0] pend,
                               input int cnt, input logic err);
        chk32({nm, " Pending"},     Pending,             pend);
        chk32({nm, " OutCount"},    32'(OutCount),       32'(cnt));
        chk32({nm, " ErrSpurious"}, 32'(ErrSpurious),    32'(err));
    endtask

    initial begin
        // --------------------------------------------------------------
        // Vector table (MAX_OUT = 4)
        //            name          v rs1 rs2 rd rw lo dn rdw pc  {St,FD,FE} pend cnt err
        vecs.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'd0, 0, 0));
        vecs.push_back(mk("issue_x5",   1, 0, 0, 5, 1, 1, 0, 0, 0, 3'b000, b(5), 1, 0));
        vecs.push_back(mk("loaduse",    1, 5, 0,10, 1, 1, 0, 0, 0, 3'b101, b(5), 1, 0));
        vecs.push_back(mk("use_done",   1, 5, 0,10, 1, 1, 1, 5, 0, 3'b000, b(10), 1, 0));
        vecs.push_back(mk("done_x10",   0, 0, 0, 0, 0, 0, 1,10, 0, 3'b000, 32'd0, 0, 0));
        vecs.push_back(mk("issue_x1",   1, 0, 0, 1, 1, 1, 0, 0, 0, 3'b000, b(1), 1, 0));
        vecs.push_back(mk("issue_x2",   1, 0, 0, 2, 1, 1, 0, 0, 0, 3'b000, b(1)|b(2), 2, 0));
        vecs.push_back(mk("issue_x3",   1, 0, 0, 3, 1, 1, 0, 0, 0, 3'b000, b(1)|b(2)|b(3), 3, 0));
        vecs.push_back(mk("issue_x4",   1, 0, 0, 4, 1, 1, 0, 0, 0, 3'b000, b(1)|b(2)|b(3)|b(4), 4, 0));
        vecs.push_back(mk("cap_stall",  1, 0, 0, 6, 1, 1, 0, 0, 0, 3'b101, b(1)|b(2)|b(3)|b(4), 4, 0));
        vecs.push_back(mk("cap_done",   1, 0, 0, 6, 1, 1, 1, 1, 0, 3'b000, b(2)|b(3)|b(4)|b(6), 4, 0));
        vecs.push_back(mk("waw_x2",     1, 0, 0, 2, 1, 0, 0, 0, 0, 3'b101, b(2)|b(3)|b(4)|b(6), 4, 0));
        vecs.push_back(mk("raw_rs2",    1, 0, 4,11, 1, 0, 0, 0, 0, 3'b101, b(2)|b(3)|b(4)|b(6), 4, 0));
        vecs.push_back(mk("flush_raw",  1, 3, 0,11, 1, 0, 0, 0, 1, 3'b011, b(2)|b(3)|b(4)|b(6), 4, 0));
        vecs.push_back(mk("flush_long", 1, 3, 0,12, 1, 1, 0, 0, 1, 3'b011, b(2)|b(3)|b(4)|b(6), 4, 0));
        vecs.push_back(mk("done_x2",    0, 0, 0, 0, 0, 0, 1, 2, 0, 3'b000, b(3)|b(4)|b(6), 3, 0));
        vecs.push_back(mk("done_x3",    0, 0, 0, 0, 0, 0, 1, 3, 0, 3'b000, b(4)|b(6), 2, 0));
        vecs.push_back(mk("done_x4",    0, 0, 0, 0, 0, 0, 1, 4, 0, 3'b000, b(6), 1, 0));
        vecs.push_back(mk("done_x6",    0, 0, 0, 0, 0, 0, 1, 6, 0, 3'b000, 32'd0, 0, 0));
        vecs.push_back(mk("issue_x7",   1, 0, 0, 7, 1, 1, 0, 0, 0, 3'b000, b(7), 1, 0));
        vecs.push_back(mk("same_reg7",  1, 0, 0, 7, 1, 1, 1, 7, 0, 3'b000, b(7), 1, 0));
        vecs.push_back(mk("short_x8",   1, 0, 0, 8, 1, 0, 0, 0, 0, 3'b000, b(7), 1, 0));
        vecs.push_back(mk("done_x7",    0, 0, 0, 0, 0, 0, 1, 7, 0, 3'b000, 32'd0, 0, 0));
        vecs.push_back(mk("spur_x9",    0, 0, 0, 0, 0, 0, 1, 9, 0, 3'b000, 32'd0, 0, 1));
        vecs.push_back(mk("spur_x0",    0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 32'd0, 0, 1));
        vecs.push_back(mk("rd0_long",   1, 0, 0, 0, 1, 1, 0, 0, 0, 3'b000, 32'd0, 0, 1));

        // --------------------------------------------------------------
        // Reset state
        rst = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 32'd0, 0, 0);
        chk32("reset stall/flush", 32'({Stall_D, Flush_D, Flush_E}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // --------------------------------------------------------------
        // Table-driven vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw,
                  vecs[i].lo, vecs[i].dn, vecs[i].rdw, vecs[i].pc);
            #1;
            chk32({vecs[i].name, " {Stall_D,Flush_D,Flush_E}"},
                  32'({Stall_D, Flush_D, Flush_E}), 32'(vecs[i].exp_sff));
            chk32({vecs[i].name, " Stall_F"}, 32'(Stall_F), 32'(vecs[i].exp_sff[2]));
            @(posedge clk);
            #1;
            check_state(vecs[i].name, vecs[i].exp_pend, vecs[i].exp_cnt, vecs[i].exp_err);
        end

        // --------------------------------------------------------------
        // Async reset mid-operation: build OutCount=3 (ErrSpurious is set)
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            drive(1, 0, 0, r, 1, 1, 0, 0, 0);
        end
        @(negedge clk);
        idle();
        #1;
        check_state("pre_reset", b(1)|b(2)|b(3), 3, 1);
        #2;  // between edges, away from negedge
        rst = 1'b0;
        #1;
        check_state("async_reset", 32'd0, 0, 0);
        // Decode sees a would-be RAW on x1, but state is cleared
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk32("reset stall_outputs", 32'({Stall_D, Stall_F, Flush_D, Flush_E}), 32'd0);
        // Long op held during reset edges must not be recorded
        drive(1, 0, 0, 5, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check_state("held_in_reset", 32'd0, 0, 0);
        @(negedge clk);
        idle();
        rst = 1'b1;

        // Late completion for a discarded entry
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #1;
        check_state("discarded_done", 32'd0, 0, 1);

        // Operation resumes on the first edge after release
        @(negedge clk);
        drive(1, 0, 0, 13, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        check_state("resume_issue", b(13), 1, 1);
        @(negedge clk);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the bench always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
